// File: rtl/arilla_bus_arbiter.sv
// Two-master, one-slave arbiter for the Arilla memory bus.
// Round-robin or fixed-priority grant, with a bounded lock for atomic sequences.
module arilla_bus_arbiter #(
  parameter int DataWidth        = 32,
  parameter int ByteAddressWidth = 32,
  parameter int ByteSize         = 8,
  parameter bit FixedPriority    = 1'b0,
  parameter int MaxLocked        = 8,
  localparam int BeW             = DataWidth / ByteSize
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic [ByteAddressWidth-1:0] m0_address,
  input  logic                        m0_read,
  input  logic                        m0_write,
  input  logic [DataWidth-1:0]        m0_write_data,
  input  logic [BeW-1:0]              m0_byte_enable,
  input  logic                        m0_lock,
  output logic [DataWidth-1:0]        m0_read_data,
  output logic                        m0_available,

  input  logic [ByteAddressWidth-1:0] m1_address,
  input  logic                        m1_read,
  input  logic                        m1_write,
  input  logic [DataWidth-1:0]        m1_write_data,
  input  logic [BeW-1:0]              m1_byte_enable,
  input  logic                        m1_lock,
  output logic [DataWidth-1:0]        m1_read_data,
  output logic                        m1_available,

  output logic [ByteAddressWidth-1:0] s_address,
  output logic                        s_read,
  output logic                        s_write,
  output logic [DataWidth-1:0]        s_write_data,
  output logic [BeW-1:0]              s_byte_enable,
  input  logic [DataWidth-1:0]        s_read_data,
  input  logic                        s_available,

  output logic [1:0]                  grant
);

  localparam int LockW = $clog2(MaxLocked + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;

  logic req0, req1;
  logic sel1, req_x, lock_x;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign sel1   = (state_q == GRANT1);
  assign req_x  = sel1 ? req1 : req0;
  assign lock_x = sel1 ? m1_lock : m0_lock;

  // Ties go to master 0 under fixed priority, otherwise to the one not served last.
  function automatic state_e arbitrate(input logic r0, input logic r1, input logic lst);
    state_e nxt;
    nxt = IDLE;
    if (r0 && r1) begin
      nxt = (FixedPriority || lst) ? GRANT0 : GRANT1;
    end else if (r0) begin
      nxt = GRANT0;
    end else if (r1) begin
      nxt = GRANT1;
    end
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        state_d = arbitrate(req0, req1, last_q);
      end
      GRANT0, GRANT1: begin
        if (!req_x) begin
          // Master withdrew mid-transaction: drop the grant cleanly.
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (s_available) begin
          last_d = sel1;
          if (lock_x && (int'(lock_cnt_q) + 1 < MaxLocked)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            lock_cnt_d = '0;
            state_d    = arbitrate(req0, req1, sel1);
          end
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    s_address     = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_write_data  = '0;
    s_byte_enable = '0;
    m0_available  = 1'b0;
    m0_read_data  = '0;
    m1_available  = 1'b0;
    m1_read_data  = '0;
    grant         = 2'b00;
    case (state_q)
      GRANT0: begin
        s_address     = m0_address;
        s_read        = m0_read;
        s_write       = m0_write & ~m0_read;
        s_write_data  = m0_write_data;
        s_byte_enable = m0_byte_enable;
        m0_available  = s_available & req0;
        m0_read_data  = s_read_data;
        grant         = 2'b01;
      end
      GRANT1: begin
        s_address     = m1_address;
        s_read        = m1_read;
        s_write       = m1_write & ~m1_read;
        s_write_data  = m1_write_data;
        s_byte_enable = m1_byte_enable;
        m1_available  = s_available & req1;
        m1_read_data  = s_read_data;
        grant         = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Directed bench for arilla_bus_arbiter: a round-robin instance (MaxLocked=3)
// and a fixed-priority instance (MaxLocked=8) share the same master/slave stimulus.
`timescale 1ns/1ps
module tb_arilla_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd, s_rd_data;
  logic        m0_rd, m0_wr, m0_lk, m1_rd, m1_wr, m1_lk, s_av;
  logic [3:0]  m0_be, m1_be;

  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wd;
  logic        rr_m0_av, rr_m1_av, rr_s_rd, rr_s_wr;
  logic [3:0]  rr_s_be;
  logic [1:0]  rr_grant;

  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wd;
  logic        fp_m0_av, fp_m1_av, fp_s_rd, fp_s_wr;
  logic [3:0]  fp_s_be;
  logic [1:0]  fp_grant;

  int checks = 0;
  int errors = 0;

  arilla_bus_arbiter #(.FixedPriority(1'b0), .MaxLocked(3)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_addr), .m0_read(m0_rd), .m0_write(m0_wr), .m0_write_data(m0_wd),
    .m0_byte_enable(m0_be), .m0_lock(m0_lk), .m0_read_data(rr_m0_rdata), .m0_available(rr_m0_av),
    .m1_address(m1_addr), .m1_read(m1_rd), .m1_write(m1_wr), .m1_write_data(m1_wd),
    .m1_byte_enable(m1_be), .m1_lock(m1_lk), .m1_read_data(rr_m1_rdata), .m1_available(rr_m1_av),
    .s_address(rr_s_addr), .s_read(rr_s_rd), .s_write(rr_s_wr), .s_write_data(rr_s_wd),
    .s_byte_enable(rr_s_be), .s_read_data(s_rd_data), .s_available(s_av), .grant(rr_grant)
  );

  arilla_bus_arbiter #(.FixedPriority(1'b1), .MaxLocked(8)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_addr), .m0_read(m0_rd), .m0_write(m0_wr), .m0_write_data(m0_wd),
    .m0_byte_enable(m0_be), .m0_lock(m0_lk), .m0_read_data(fp_m0_rdata), .m0_available(fp_m0_av),
    .m1_address(m1_addr), .m1_read(m1_rd), .m1_write(m1_wr), .m1_write_data(m1_wd),
    .m1_byte_enable(m1_be), .m1_lock(m1_lk), .m1_read_data(fp_m1_rdata), .m1_available(fp_m1_av),
    .s_address(fp_s_addr), .s_read(fp_s_rd), .s_write(fp_s_wr), .s_write_data(fp_s_wd),
    .s_byte_enable(fp_s_be), .s_read_data(s_rd_data), .s_available(s_av), .grant(fp_grant)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_addr = '0; m0_rd = 0; m0_wr = 0; m0_wd = '0; m0_be = '0; m0_lk = 0;
    m1_addr = '0; m1_rd = 0; m1_wr = 0; m1_wd = '0; m1_be = '0; m1_lk = 0;
    s_rd_data = '0; s_av = 0;
  endtask

  // Leaves the caller at a falling edge with reset released and both DUTs in IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_g [10] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b01,
                             2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
  logic [9:0] pat;
  logic [9:0] exp_m0av;
  logic [9:0] exp_m1av;
  int         m1_done;
  int         stall_done;

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset state, with a request and slave strobe present that must be ignored.
    #20;
    m0_rd = 1; m0_addr = 32'h0000_0100; s_av = 1; s_rd_data = 32'h1234_5678;
    #1;
    chk("reset_grant",  rr_grant, 2'b00);
    chk("reset_m0_av",  rr_m0_av, 1'b0);
    chk("reset_s_read", rr_s_rd,  1'b0);
    chk("reset_s_addr", rr_s_addr, 32'h0);
    chk("reset_m0_rdata", rr_m0_rdata, 32'h0);

    // Single master read (read+write together is treated as a read).
    do_reset();
    m0_rd = 1; m0_wr = 1; m0_addr = 32'h0000_0100; s_rd_data = 32'hCAFE_F00D; s_av = 1;
    #1;
    chk("single_idle_grant", rr_grant, 2'b00);
    chk("single_idle_m0_av", rr_m0_av, 1'b0);
    @(negedge clk);
    chk("single_grant",   rr_grant,    2'b01);
    chk("single_m0_av",   rr_m0_av,    1'b1);
    chk("single_m0_rdata", rr_m0_rdata, 32'hCAFE_F00D);
    chk("single_s_addr",  rr_s_addr,   32'h0000_0100);
    chk("single_s_read",  rr_s_rd,     1'b1);
    chk("single_s_write", rr_s_wr,     1'b0);
    chk("single_m1_av",   rr_m1_av,    1'b0);
    chk("single_m1_rdata", rr_m1_rdata, 32'h0);

    // Both masters writing continuously: round-robin alternates, fixed priority sticks to m0.
    do_reset();
    m0_wr = 1; m0_addr = 32'h10; m0_wd = 32'hA0A0_A0A0; m0_be = 4'b0011;
    m1_wr = 1; m1_addr = 32'h20; m1_wd = 32'hB0B0_B0B0; m1_be = 4'b1100;
    s_av = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rr_s_addr", rr_s_addr, (i % 2 == 1) ? 32'h20 : 32'h10);
      chk("rr_s_wdata", rr_s_wd, (i % 2 == 1) ? 32'hB0B0_B0B0 : 32'hA0A0_A0A0);
      chk("rr_s_be",    rr_s_be, (i % 2 == 1) ? 4'b1100 : 4'b0011);
      chk("rr_grant",   rr_grant, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("rr_s_write", rr_s_wr, 1'b1);
      chk("fp_s_addr",  fp_s_addr, 32'h10);
      chk("fp_m1_av",   fp_m1_av, 1'b0);
      @(negedge clk);
    end

    // Lock: m1 keeps the grant for exactly 3 completions, then m0 gets it.
    do_reset();
    m1_rd = 1; m1_lk = 1; m1_addr = 32'h30; s_rd_data = 32'h0BAD_BEEF; s_av = 1;
    m1_done = 0;
    @(negedge clk);
    m0_rd = 1; m0_addr = 32'h34;
    for (int j = 0; j < 3; j++) begin
      chk("lock_grant", rr_grant, 2'b10);
      chk("lock_m0_av", rr_m0_av, 1'b0);
      if (rr_m1_av) m1_done++;
      @(negedge clk);
    end
    chk("lock_m1_done",    m1_done,  3);
    chk("release_grant",   rr_grant, 2'b01);
    chk("release_m0_av",   rr_m0_av, 1'b1);
    chk("release_m1_av",   rr_m1_av, 1'b0);
    chk("fp_lock_hold",    fp_grant, 2'b10);

    // Slave stall: s_available 1,1,1,0,0 repeating, both masters reading.
    do_reset();
    m0_rd = 1; m0_addr = 32'h40; m1_rd = 1; m1_addr = 32'h80; s_rd_data = 32'h5555_AAAA;
    pat      = 10'b0011100111;
    exp_m0av = 10'b0010100010;
    exp_m1av = 10'b0001000100;
    stall_done = 0;
    for (int k = 0; k < 10; k++) begin
      s_av = pat[k];
      #1;
      chk("stall_grant", rr_grant, exp_g[k]);
      chk("stall_m0_av", rr_m0_av, exp_m0av[k]);
      chk("stall_m1_av", rr_m1_av, exp_m1av[k]);
      chk("stall_one_hot_av", rr_m0_av & rr_m1_av, 1'b0);
      stall_done += int'(rr_m0_av) + int'(rr_m1_av);
      @(negedge clk);
    end
    chk("stall_completions", stall_done, 5);

    // Master withdraws during a stalled transaction: back to IDLE.
    do_reset();
    m1_rd = 1; m1_addr = 32'h60;
    @(negedge clk);
    chk("abort_granted", rr_grant, 2'b10);
    m1_rd = 0;
    @(negedge clk);
    chk("abort_idle", rr_grant, 2'b00);

    // Asynchronous reset during GRANT1 with the slave stalled.
    m1_rd = 1; s_rd_data = 32'h7777_7777;
    @(negedge clk);
    chk("midrst_pre_grant", rr_grant, 2'b10);
    chk("midrst_pre_addr",  rr_s_addr, 32'h60);
    #10;
    m0_rd = 1; m0_addr = 32'h44; s_av = 1; rst_n = 0;
    #1;
    chk("midrst_grant",  rr_grant,    2'b00);
    chk("midrst_s_read", rr_s_rd,     1'b0);
    chk("midrst_s_addr", rr_s_addr,   32'h0);
    chk("midrst_m1_av",  rr_m1_av,    1'b0);
    chk("midrst_m1_rdata", rr_m1_rdata, 32'h0);
    rst_n = 1;
    @(negedge clk);
    chk("postrst_grant", rr_grant, 2'b01);
    chk("postrst_m0_av", rr_m0_av, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
